regread_addr_sequencer: RTL
===========================

Name: regread_addr_sequencer

Overview:
- Registered, handshaked successor to the combinational register-file read-address selector.
- Takes a decoded instruction's rs/rt/rd fields plus an op class. Produces the two register-file read addresses (readA/readB) one cycle later.
- Supports parametrised register-address width and special-register indices.
- Adds a two-beat TRIPLE mode for ops that need rs, rt and rd, a flush input, and valid/ready backpressure. Sits between decode and the register file in the 5-stage pipeline.

Parameters:
REG_AW, 5, register address width in bits
STATUS_REG, 30, index driven on readA for branch-with-exception
ZERO_REG, 0, index driven as a don't-care or zero read

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  drop in-flight and pending work
in_valid  in  1  decode offers an instruction
in_ready  out  1  block accepts this cycle
op_class  in  3  0=ALU 1=MEM 2=BR 3=JR 4=TRIPLE 5..7=reserved
exc  in  1  exception pending (used by BR only)
rs  in  REG_AW  source field
rt  in  REG_AW  target field
rd  in  REG_AW  destination field
out_valid  out  1  readA/readB valid
out_ready  in  1  downstream consumes
readA  out  REG_AW  read port A address
readB  out  REG_AW  read port B address
out_last  out  1  final beat of this instruction
err_op  out  1  sticky: reserved op_class was accepted

Behaviour:
- Reset: state=S_ONE. out_valid=0, readA=readB=ZERO_REG, out_last=0, err_op=0.
- Output register advance: adv = !out_valid || out_ready.
- in_ready = adv && state==S_ONE && !flush.
- Accept (in_valid && in_ready): the output register loads on the next edge, so latency is 1 cycle. Mapping:
  - ALU: A=rs, B=rt, last=1
  - MEM: A=rs, B=rd, last=1
  - BR, exc=0: A=rd, B=rs, last=1
  - BR, exc=1: A=STATUS_REG, B=ZERO_REG, last=1
  - JR: A=rd, B=rs, last=1; exc is ignored
  - TRIPLE: beat0 A=rs, B=rt, last=0. Latch rd and go to S_SECOND.
  - 5..7: mapped as ALU; err_op is set to 1 and stays set until reset.
- S_SECOND: on adv, load A=latched rd, B=ZERO_REG, last=1, then return to S_ONE. in_ready=0 throughout S_SECOND.
- Hold: when out_valid && !out_ready, readA/readB/out_last hold stable. No input is accepted.
- Consume without new accept: when out_valid && out_ready and no accept and state==S_ONE, out_valid goes to 0 next cycle. readA/readB keep their last value.
- Back-to-back: a new accept in the same cycle the current beat is consumed keeps out_valid=1 with no bubble.
- Flush (priority over everything except reset): on the next edge out_valid=0 and state=S_ONE. Any pending TRIPLE beat1 is discarded. err_op is unchanged.
- Reset mid-TRIPLE: identical to reset (beat1 discarded).
- Widths: all address paths are REG_AW bits. STATUS_REG and ZERO_REG are truncated to REG_AW.

Optional Feature:
- Macro: REGREAD_STALL_CNT_EN.
- When defined:
  - Extra output stall_cnt, 16 bits.
  - Increments each cycle out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then ALU accept with rs=3, rt=7, out_ready=1 -> next cycle out_valid=1, readA=3, readB=7, out_last=1; one cycle later out_valid=0.
- BR with rd=9, rs=4: exc=0 -> A=9, B=4. exc=1 -> A=30, B=0. JR with exc=1, rd=31, rs=2 -> A=31, B=2.
- TRIPLE with rs=1, rt=2, rd=5 and out_ready held 0 for 3 cycles -> beat0 holds (1,2,last=0) and in_ready=0. After release: beat1 (5,0,last=1), then in_ready=1.
- Stream of 4 MEM ops with out_ready=1 -> 4 consecutive out_valid cycles with no bubbles; each beat has A=rs, B=rd.
- TRIPLE accepted, flush asserted during beat0 -> next cycle out_valid=0 and beat1 never appears. A simultaneous in_valid is not accepted (in_ready=0).
- op_class=6 accepted -> mapped as ALU and err_op=1 stays set across later ops. With REGREAD_STALL_CNT_EN: 5 stalled cycles -> stall_cnt=5, and stall_cnt stays 5 after a flush.

Source files
------------

// File: rtl/regread_addr_sequencer_if.sv
// Handshake bundle between decode, the read-address sequencer and the register file.
// master = decode/regfile side, slave = sequencer side.
interface regread_addr_sequencer_if #(
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_class;
    logic              exc;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic [REG_AW-1:0] readA;
    logic [REG_AW-1:0] readB;
    logic              out_last;

    modport master (
        output in_valid, op_class, exc, rs, rt, rd, out_ready,
        input  in_ready, out_valid, readA, readB, out_last
    );

    modport slave (
        input  in_valid, op_class, exc, rs, rt, rd, out_ready,
        output in_ready, out_valid, readA, readB, out_last
    );
endinterface

// File: rtl/regread_addr_sequencer.sv
// Registered register-file read-address sequencer with two-beat TRIPLE ops.
// Optional 16-bit stall counter output enabled by REGREAD_STALL_CNT_EN.
module regread_addr_sequencer #(
    parameter int REG_AW     = 5,
    parameter int STATUS_REG = 30,
    parameter int ZERO_REG   = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    regread_addr_sequencer_if.slave io,
    output logic err_op
`ifdef REGREAD_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam logic [REG_AW-1:0] STATUS_A = REG_AW'(STATUS_REG);
    localparam logic [REG_AW-1:0] ZERO_A   = REG_AW'(ZERO_REG);

    typedef enum logic {
        S_ONE,
        S_SECOND
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [REG_AW-1:0] a_q, a_d;
    logic [REG_AW-1:0] b_q, b_d;
    logic              last_q, last_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic              adv;
    logic              in_ready;
    logic              accept;

    assign adv      = !valid_q || io.out_ready;
    assign in_ready = adv && (state_q == S_ONE) && !flush;
    assign accept   = io.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        rd_d    = rd_q;
        err_d   = err_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = S_ONE;
        end else if (state_q == S_SECOND) begin
            if (adv) begin
                valid_d = 1'b1;
                a_d     = rd_q;
                b_d     = ZERO_A;
                last_d  = 1'b1;
                state_d = S_ONE;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            unique case (1'b1)
                (io.op_class == 3'd0): begin
                    a_d = io.rs;
                    b_d = io.rt;
                end
                (io.op_class == 3'd1): begin
                    a_d = io.rs;
                    b_d = io.rd;
                end
                (io.op_class == 3'd2): begin
                    a_d = io.exc ? STATUS_A : io.rd;
                    b_d = io.exc ? ZERO_A : io.rs;
                end
                (io.op_class == 3'd3): begin
                    a_d = io.rd;
                    b_d = io.rs;
                end
                (io.op_class == 3'd4): begin
                    a_d     = io.rs;
                    b_d     = io.rt;
                    last_d  = 1'b0;
                    rd_d    = io.rd;
                    state_d = S_SECOND;
                end
                default: begin
                    // reserved classes still flow through as ALU reads
                    a_d   = io.rs;
                    b_d   = io.rt;
                    err_d = 1'b1;
                end
            endcase
        end else if (io.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ONE;
            valid_q <= 1'b0;
            a_q     <= ZERO_A;
            b_q     <= ZERO_A;
            last_q  <= 1'b0;
            rd_q    <= ZERO_A;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

`ifdef REGREAD_STALL_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (valid_q && !io.out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cnt = cnt_q;
`endif

    assign io.in_ready  = in_ready;
    assign io.out_valid = valid_q;
    assign io.readA     = a_q;
    assign io.readB     = b_q;
    assign io.out_last  = last_q;
    assign err_op       = err_q;
endmodule
